// File: rtl/stack_unit_if.sv
// Request/response bundle between the decode stage and the return-address stack.
// The decode stage drives the master side and the stack drives the slave side.
interface stack_unit_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;
  logic              err_clr;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              err;

  modport master (
    output push, pop, push_data, err_clr,
    input  pop_data, pop_valid, top, count, full, empty, err
  );

  modport slave (
    input  push, pop, push_data, err_clr,
    output pop_data, pop_valid, top, count, full, empty, err
  );
endinterface

// File: rtl/stack_unit.sv
// Return-address stack with a registered pop output and full/empty status.
// Define STACK_ERR_EN to get a sticky overflow/underflow flag on err (cleared by err_clr).
module stack_unit #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  stack_unit_if.slave   bus
);
  localparam int IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  sp;
  logic [DATA_W-1:0] pop_data_q;
  logic              pop_valid_q;
  logic              is_full;
  logic              is_empty;
  logic              pop_ok;
  logic              push_ok;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  wr_idx;

  assign is_full  = (sp == CNT_W'(DEPTH));
  assign is_empty = (sp == '0);
  assign top_idx  = IDX_W'(sp - CNT_W'(1));

  // A push is still accepted while full when it pairs with a pop (replace).
  assign pop_ok  = bus.pop && !is_empty;
  assign push_ok = bus.push && (pop_ok || !is_full);
  assign wr_idx  = pop_ok ? top_idx : IDX_W'(sp);

  always_ff @(posedge clk) begin
    if (!rst) begin
      sp          <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
    end else begin
      pop_valid_q <= pop_ok;
      if (pop_ok)
        pop_data_q <= mem[top_idx];
      if (pop_ok && !bus.push)
        sp <= sp - CNT_W'(1);
      else if (push_ok && !pop_ok)
        sp <= sp + CNT_W'(1);
    end
  end

  // Storage is deliberately not reset; only the pointer defines validity.
  always_ff @(posedge clk) begin
    if (rst && push_ok)
      mem[wr_idx] <= bus.push_data;
  end

`ifdef STACK_ERR_EN
  logic err_q;
  logic err_set;

  assign err_set = (bus.push && !bus.pop && is_full) || (bus.pop && is_empty);

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (err_set)
      err_q <= 1'b1;
    else if (bus.err_clr)
      err_q <= 1'b0;
  end

  assign bus.err = err_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err        = 1'b0;
`endif

  assign bus.pop_data  = pop_data_q;
  assign bus.pop_valid = pop_valid_q;
  assign bus.top       = is_empty ? '0 : mem[top_idx];
  assign bus.count     = sp;
  assign bus.full      = is_full;
  assign bus.empty     = is_empty;
endmodule
